// File: rtl/aes_round_key_deskew_buffer_pkg.sv
// Shared constants for the round-key deskew buffer: key-schedule geometry,
// the slice placement helper and the FIPS-197 reference round keys.
package aes_round_key_deskew_buffer_pkg;

  localparam int DATA_W    = 128;
  localparam int NO_ROUNDS = 10;
  localparam int IDX_W     = 4;
  localparam int DEPTH     = 2;

  // Round key 1 sits in the MSB slice, so slice j starts this many bits up.
  function automatic int sliceLsb(input int j, input int nRounds, input int dataW);
    return (nRounds - 1 - j) * dataW;
  endfunction

  localparam logic [127:0] FIPS_CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  localparam logic [127:0] FIPS_ROUND_KEYS [10] = '{
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

endpackage

// File: rtl/aes_skew_delay.sv
// Fixed-length delay line carrying a data word and its valid bit;
// zero stages degenerates to a plain wire.
module aes_skew_delay
  import aes_round_key_deskew_buffer_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  if (STAGES == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk ^ reset;
    assign o_data   = i_data;
    assign o_valid  = i_valid;
  end else begin : g_line
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES-1:0] r_valid;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
        r_valid <= '0;
      end else begin
        r_data[0]  <= i_data;
        r_valid[0] <= i_valid;
        for (int k = 1; k < STAGES; k++) begin
          r_data[k]  <= r_data[k-1];
          r_valid[k] <= r_valid[k-1];
        end
      end
    end

    assign o_data  = r_data[STAGES-1];
    assign o_valid = r_valid[STAGES-1];
  end

endmodule

// File: rtl/aes_round_key_deskew_buffer.sv
// Realigns the staggered round keys from the key expansion pipeline into
// complete per-key sets and queues them for the cipher datapath.
module aes_round_key_deskew_buffer #(
  parameter int DATA_W    = aes_round_key_deskew_buffer_pkg::DATA_W,
  parameter int NO_ROUNDS = aes_round_key_deskew_buffer_pkg::NO_ROUNDS,
  parameter int DEPTH     = aes_round_key_deskew_buffer_pkg::DEPTH,
  parameter int IDX_W     = aes_round_key_deskew_buffer_pkg::IDX_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NO_ROUNDS*DATA_W-1:0] kx_w,
  input  logic [NO_ROUNDS-1:0]        kx_valid,
  output logic                        set_valid,
  input  logic                        set_ready,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [DATA_W-1:0]           rd_key,
  output logic [IDX_W-1:0]            set_count,
  output logic                        overflow,
  output logic                        seq_err
);
  import aes_round_key_deskew_buffer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]    w_dKey [NO_ROUNDS];
  logic [NO_ROUNDS-1:0] w_dValid;

  // Earlier round keys arrive earlier, so they are held back the longest.
  for (genvar j = 0; j < NO_ROUNDS; j++) begin : g_stage
    localparam int LSB = sliceLsb(j, NO_ROUNDS, DATA_W);
    aes_skew_delay #(
      .WIDTH (DATA_W),
      .STAGES(NO_ROUNDS - 1 - j)
    ) u_delay (
      .clk    (clk),
      .reset  (reset),
      .i_data (kx_w[LSB +: DATA_W]),
      .i_valid(kx_valid[j]),
      .o_data (w_dKey[j]),
      .o_valid(w_dValid[j])
    );
  end

  logic [DATA_W-1:0] r_mem [DEPTH][NO_ROUNDS];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [IDX_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_seqErr;

  logic w_aligned, w_empty, w_full, w_pop, w_push, w_mismatch;

  assign w_aligned  = w_dValid[NO_ROUNDS-1];
  assign w_empty    = (r_count == '0);
  assign w_full     = (int'(r_count) == DEPTH);
  assign w_pop      = !w_empty && set_ready;
  assign w_push     = w_aligned && (!w_full || w_pop);
  assign w_mismatch = (|w_dValid) && !(&w_dValid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++)
        for (int k = 0; k < NO_ROUNDS; k++) r_mem[e][k] <= '0;
    end else if (w_push) begin
      for (int k = 0; k < NO_ROUNDS; k++) r_mem[r_wrPtr][k] <= w_dKey[k];
    end
  end

  // Occupancy is tracked by its own counter so full and empty stay distinct.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_seqErr   <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_aligned && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_mismatch) r_seqErr <= 1'b1;
    end
  end

  always_comb begin
    rd_key = '0;
    if (!w_empty && int'(rd_idx) < NO_ROUNDS) rd_key = r_mem[r_rdPtr][rd_idx];
  end

  assign set_valid = !w_empty;
  assign set_count = r_count;
  assign overflow  = r_overflow;
  assign seq_err   = r_seqErr;

endmodule

// File: tb/tb_aes_round_key_deskew_buffer.sv
// Self-checking bench: models the skewed key expansion output and an ideal
// set queue, then compares the buffer against that model scenario by scenario.
`timescale 1ns/1ps
module tb_aes_round_key_deskew_buffer;
  import aes_round_key_deskew_buffer_pkg::*;

  localparam int NR = NO_ROUNDS;
  localparam int DW = DATA_W;
  localparam int DP = 2;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR*DW-1:0] kx_w = '0;
  logic [NR-1:0]    kx_valid = '0;
  logic             set_valid;
  logic             set_ready = 1'b0;
  logic [IW-1:0]    rd_idx = '0;
  logic [DW-1:0]    rd_key;
  logic [IW-1:0]    set_count;
  logic             overflow;
  logic             seq_err;

  always #5 clk = ~clk;

  aes_round_key_deskew_buffer #(.DATA_W(DW), .NO_ROUNDS(NR), .DEPTH(DP), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .kx_w(kx_w), .kx_valid(kx_valid),
    .set_valid(set_valid), .set_ready(set_ready), .rd_idx(rd_idx), .rd_key(rd_key),
    .set_count(set_count), .overflow(overflow), .seq_err(seq_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] keyStore [256][NR];
  int            pipe [NR];
  int            q[$];
  logic          ovfExp;
  int            nextId;
  logic [NR-1:0] injectMask;

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] expKey(input int idx);
    if (q.size() == 0 || idx >= NR) return '0;
    return keyStore[q[0]][idx];
  endfunction

  task automatic makeKey(output int id);
    id = nextId;
    nextId++;
    for (int k = 0; k < NR; k++) keyStore[id][k] = rand128();
  endtask

  // One clock: present the expansion pipeline contents, update the ideal queue, shift the pipeline.
  task automatic tick(input int newId, input logic ready);
    bit pop, full;
    int arriving;
    for (int j = 0; j < NR; j++) begin
      kx_w[(NR-j)*DW-1 -: DW] = (pipe[j] >= 0) ? keyStore[pipe[j]][j] : rand128();
      kx_valid[j] = (pipe[j] >= 0) || injectMask[j];
    end
    set_ready = ready;
    pop      = (q.size() > 0) && ready;
    full     = (q.size() == DP);
    arriving = pipe[NR-1];
    if (pop) void'(q.pop_front());
    if (arriving >= 0) begin
      if (!full || pop) q.push_back(arriving);
      else ovfExp = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int j = NR-1; j > 0; j--) pipe[j] = pipe[j-1];
    pipe[0] = newId;
  endtask

  task automatic clearModel();
    for (int j = 0; j < NR; j++) pipe[j] = -1;
    q.delete();
    ovfExp     = 1'b0;
    nextId     = 1;
    injectMask = '0;
    kx_valid   = '0;
    set_ready  = 1'b0;
  endtask

  task automatic doReset();
    clearModel();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearModel();
    #1 reset = 1'b0;
    #2;
    checks++; if (set_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_set_valid: got %b expected 0", set_valid); end
    checks++; if (set_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_set_count: got %0d expected 0", set_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_seq_err: got %b expected 0", seq_err); end
    checks++; if (rd_key !== '0) begin errors++; $display("[TB] FAIL reset_rd_key: got %h expected 0", rd_key); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_key();
    doReset();
    for (int k = 0; k < NR; k++) keyStore[0][k] = FIPS_ROUND_KEYS[k];
    tick(0, 1'b0);
    for (int c = 2; c <= 10; c++) tick(-1, 1'b0);
    checks++; if (set_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early: got %b expected 0 after 10 cycles", set_valid); end
    tick(-1, 1'b0);
    checks++; if (set_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: got %b expected 1 after 11 cycles", set_valid); end
    checks++; if (set_count !== 4'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", set_count); end
    rd_idx = 4'd0; #1;
    checks++; if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("[TB] FAIL single_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", rd_key); end
    rd_idx = 4'd9; #1;
    checks++; if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("[TB] FAIL single_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key); end
    for (int i = 1; i < 9; i++) begin
      rd_idx = IW'(i); #1;
      checks++; if (rd_key !== expKey(i)) begin errors++; $display("[TB] FAIL single_rk idx %0d: got %h expected %h", i, rd_key, expKey(i)); end
    end
  endtask

  task automatic test_back_to_back();
    int a, b;
    doReset();
    makeKey(a);
    makeKey(b);
    tick(a, 1'b0);
    tick(b, 1'b0);
    for (int c = 3; c <= 12; c++) tick(-1, 1'b0);
    checks++; if (set_count !== 4'd2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", set_count); end
    rd_idx = 4'd9; #1;
    checks++; if (rd_key !== keyStore[a][9]) begin errors++; $display("[TB] FAIL b2b_head_a: got %h expected %h", rd_key, keyStore[a][9]); end
    rd_idx = 4'd0; #1;
    checks++; if (rd_key !== keyStore[a][0]) begin errors++; $display("[TB] FAIL b2b_head_a0: got %h expected %h", rd_key, keyStore[a][0]); end
    tick(-1, 1'b1);
    rd_idx = 4'd9; #1;
    checks++; if (rd_key !== keyStore[b][9]) begin errors++; $display("[TB] FAIL b2b_head_b: got %h expected %h", rd_key, keyStore[b][9]); end
    checks++; if (set_count !== 4'd1) begin errors++; $display("[TB] FAIL b2b_count_pop: got %0d expected 1", set_count); end
  endtask

  task automatic test_overflow();
    int ids [3];
    doReset();
    for (int i = 0; i < 3; i++) makeKey(ids[i]);
    for (int c = 1; c <= 14; c++) tick((c <= 3) ? ids[c-1] : -1, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (set_count !== 4'd2) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 2", set_count); end
    tick(-1, 1'b1);
    rd_idx = 4'd5; #1;
    checks++; if (rd_key !== keyStore[ids[1]][5]) begin errors++; $display("[TB] FAIL ovf_second_head: got %h expected %h", rd_key, keyStore[ids[1]][5]); end
    tick(-1, 1'b1);
    checks++; if (set_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_third_absent: got %b expected 0", set_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end

    doReset();
    for (int i = 0; i < 3; i++) makeKey(ids[i]);
    for (int c = 1; c <= 13; c++) tick((c <= 3) ? ids[c-1] : -1, (c == 13));
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pop_flag: got %b expected 0", overflow); end
    checks++; if (set_count !== 4'd2) begin errors++; $display("[TB] FAIL ovf_pop_count: got %0d expected 2", set_count); end
    rd_idx = 4'd3; #1;
    checks++; if (rd_key !== keyStore[ids[1]][3]) begin errors++; $display("[TB] FAIL ovf_pop_head: got %h expected %h", rd_key, keyStore[ids[1]][3]); end
  endtask

  task automatic test_reset_midflight();
    int p, a;
    doReset();
    makeKey(p);
    makeKey(a);
    tick(p, 1'b0);
    for (int c = 2; c <= 11; c++) tick(-1, 1'b0);
    tick(a, 1'b0);
    for (int c = 1; c <= 5; c++) tick(-1, 1'b0);
    rd_idx = 4'd0;
    #2 reset = 1'b0;
    #1;
    checks++; if (set_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", set_valid); end
    checks++; if (set_count !== 4'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", set_count); end
    checks++; if (rd_key !== '0) begin errors++; $display("[TB] FAIL midrst_rd_key: got %h expected 0", rd_key); end
    @(posedge clk);
    #1 reset = 1'b1;
    clearModel();
    for (int c = 0; c < 20; c++) begin
      tick(-1, 1'b1);
      checks++; if (set_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after cycle %0d: got %b expected 0", c, set_valid); end
    end
    checks++; if (set_count !== 4'd0) begin errors++; $display("[TB] FAIL midrst_after_count: got %0d expected 0", set_count); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_seq_err: got %b expected 0", seq_err); end
  endtask

  task automatic test_seq_err();
    doReset();
    checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL seq_before: got %b expected 0", seq_err); end
    injectMask = NR'(1) << 3;
    tick(-1, 1'b0);
    injectMask = '0;
    for (int c = 0; c < 7; c++) tick(-1, 1'b0);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("[TB] FAIL seq_set: got %b expected 1", seq_err); end
    for (int c = 0; c < 5; c++) tick(-1, 1'b0);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("[TB] FAIL seq_sticky: got %b expected 1", seq_err); end
    checks++; if (set_count !== 4'd0) begin errors++; $display("[TB] FAIL seq_no_write: got %0d expected 0", set_count); end
    checks++; if (set_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_no_valid: got %b expected 0", set_valid); end
  endtask

  task automatic test_index_bounds();
    int a;
    doReset();
    for (int i = 0; i < 16; i++) begin
      rd_idx = IW'(i); #1;
      checks++; if (rd_key !== '0) begin errors++; $display("[TB] FAIL idx_empty %0d: got %h expected 0", i, rd_key); end
    end
    makeKey(a);
    tick(a, 1'b0);
    for (int c = 2; c <= 11; c++) tick(-1, 1'b0);
    rd_idx = 4'd10; #1;
    checks++; if (rd_key !== '0) begin errors++; $display("[TB] FAIL idx_10: got %h expected 0", rd_key); end
    rd_idx = 4'd15; #1;
    checks++; if (rd_key !== '0) begin errors++; $display("[TB] FAIL idx_15: got %h expected 0", rd_key); end
    rd_idx = 4'd7; #1;
    checks++; if (rd_key !== keyStore[a][7]) begin errors++; $display("[TB] FAIL idx_7: got %h expected %h", rd_key, keyStore[a][7]); end
  endtask

  task automatic test_random_traffic();
    int id;
    doReset();
    for (int c = 0; c < 300; c++) begin
      id = -1;
      if ($urandom_range(0, 2) == 0) makeKey(id);
      tick(id, ($urandom_range(0, 1) == 1));
      rd_idx = IW'($urandom_range(0, 15));
      #1;
      checks++; if (set_valid !== (q.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid cycle %0d: got %b expected %b", c, set_valid, q.size() > 0); end
      checks++; if (set_count !== IW'(q.size())) begin errors++; $display("[TB] FAIL rnd_count cycle %0d: got %0d expected %0d", c, set_count, q.size()); end
      checks++; if (overflow !== ovfExp) begin errors++; $display("[TB] FAIL rnd_overflow cycle %0d: got %b expected %b", c, overflow, ovfExp); end
      checks++; if (rd_key !== expKey(int'(rd_idx))) begin errors++; $display("[TB] FAIL rnd_rd_key cycle %0d idx %0d: got %h expected %h", c, rd_idx, rd_key, expKey(int'(rd_idx))); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL rnd_seq_err cycle %0d: got %b expected 0", c, seq_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_back_to_back();
    test_overflow();
    test_reset_midflight();
    test_seq_err();
    test_index_bounds();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
